// File: rtl/sync_catch_if.sv
// SYNC receive bundle: the asynchronous SYNC line in, frame alignment and status out.
interface sync_catch_if #(
    parameter int unsigned CNT_W = 10
);
    logic             sync_in;
    logic             frame_start;
    logic [CNT_W-1:0] frame_pos;
    logic             aligned;
    logic             resync;
    logic [7:0]       resync_count;
    logic             sync_timeout;

    // Upstream/consumer side: drives SYNC, observes alignment.
    modport master (
        output sync_in,
        input  frame_start,
        input  frame_pos,
        input  aligned,
        input  resync,
        input  resync_count,
        input  sync_timeout
    );

    // Receiver side.
    modport slave (
        input  sync_in,
        output frame_start,
        output frame_pos,
        output aligned,
        output resync,
        output resync_count,
        output sync_timeout
    );
endinterface

// File: rtl/sync_catch.sv
// Receive side of the board SYNC line: synchronizes sync_in, aligns a free-running frame
// position counter to it and reports alignment, out-of-phase re-syncs and missing SYNC.
module sync_catch #(
    parameter int unsigned FRAME_LEN = 1024,
    parameter int unsigned TIMEOUT   = 1100000,
    parameter int unsigned CNT_W     = $clog2(FRAME_LEN)
) (
    input logic         clk,
    input logic         reset_n,
    sync_catch_if.slave bus
);
    localparam logic [CNT_W-1:0] LastPos    = CNT_W'(FRAME_LEN - 1);
    localparam logic [23:0]      TimeoutVal = 24'(TIMEOUT);

    if (FRAME_LEN < 2) begin : g_bad_frame_len
        $error("FRAME_LEN must be at least 2");
    end
    if (TIMEOUT >= (1 << 24)) begin : g_bad_timeout
        $error("TIMEOUT must fit in 24 bits");
    end

    typedef enum logic [0:0] {StWait, StRun} state_e;

    state_e           state_q, state_d;
    logic             s1_q, s2_q, s3_q;
    logic             s_edge;
    logic [23:0]      tmo_cnt_q, tmo_cnt_d;
    logic [CNT_W-1:0] pos_q, pos_d;
    logic             fs_q, fs_d;
    logic             aligned_q, aligned_d;
    logic             rs_q, rs_d;
    logic [7:0]       rcnt_q, rcnt_d;
    logic             tmo_q, tmo_d;

    // Two-flop synchronizer plus an edge register; a held level yields one edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= bus.sync_in;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign s_edge = s2_q & ~s3_q;

    always_comb begin
        state_d   = state_q;
        tmo_cnt_d = tmo_cnt_q;
        pos_d     = pos_q;
        fs_d      = 1'b0;
        aligned_d = aligned_q;
        rs_d      = 1'b0;
        rcnt_d    = rcnt_q;
        tmo_d     = tmo_q;

        case (state_q)
            StWait: begin
                pos_d = '0;
                if (tmo_cnt_q != TimeoutVal) begin
                    tmo_cnt_d = tmo_cnt_q + 24'd1;
                end
                // Sticky; a SYNC on the same edge still aligns.
                if (tmo_cnt_d == TimeoutVal) begin
                    tmo_d = 1'b1;
                end
                if (s_edge) begin
                    state_d   = StRun;
                    fs_d      = 1'b1;
                    aligned_d = 1'b1;
                end
            end
            StRun: begin
                if (s_edge && (pos_q != LastPos)) begin
                    pos_d = '0;
                    fs_d  = 1'b1;
                    rs_d  = 1'b1;
                    if (rcnt_q != 8'hff) begin
                        rcnt_d = rcnt_q + 8'd1;
                    end
                end else if (pos_q == LastPos) begin
                    // Natural wrap; an in-phase SYNC lands here too.
                    pos_d = '0;
                    fs_d  = 1'b1;
                end else begin
                    pos_d = pos_q + 1'b1;
                end
            end
            default: state_d = StWait;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= StWait;
            tmo_cnt_q <= '0;
            pos_q     <= '0;
            fs_q      <= 1'b0;
            aligned_q <= 1'b0;
            rs_q      <= 1'b0;
            rcnt_q    <= '0;
            tmo_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            tmo_cnt_q <= tmo_cnt_d;
            pos_q     <= pos_d;
            fs_q      <= fs_d;
            aligned_q <= aligned_d;
            rs_q      <= rs_d;
            rcnt_q    <= rcnt_d;
            tmo_q     <= tmo_d;
        end
    end

    assign bus.frame_start  = fs_q;
    assign bus.frame_pos    = pos_q;
    assign bus.aligned      = aligned_q;
    assign bus.resync       = rs_q;
    assign bus.resync_count = rcnt_q;
    assign bus.sync_timeout = tmo_q;
endmodule

// File: tb/tb_sync_catch.sv
// Randomized bench for sync_catch: two instances (long and short timeout) checked each
// cycle against a frame-level reference model plus scenario-specific expectations.
module tb_sync_catch;
    localparam int unsigned LEN_A = 16;
    localparam int unsigned TMO_A = 1000;
    localparam int unsigned LEN_B = 5;
    localparam int unsigned TMO_B = 50;
    localparam int unsigned W_A   = $clog2(LEN_A);
    localparam int unsigned W_B   = $clog2(LEN_B);

    typedef struct {
        bit       aligned;
        int       pos;
        bit       fs;
        bit       rs;
        int       rcnt;
        bit       tmo;
        int       waited;
        bit [3:0] hist;
    } model_t;

    logic   clk;
    logic   reset_n;
    int     checks;
    int     failures;
    int     cyc;
    model_t ma;
    model_t mb;

    sync_catch_if #(.CNT_W(W_A)) bus_a ();
    sync_catch_if #(.CNT_W(W_B)) bus_b ();

    sync_catch #(.FRAME_LEN(LEN_A), .TIMEOUT(TMO_A), .CNT_W(W_A)) dut_a (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_a)
    );

    sync_catch #(.FRAME_LEN(LEN_B), .TIMEOUT(TMO_B), .CNT_W(W_B)) dut_b (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic model_t model_reset();
        model_t m;
        m.aligned = 1'b0;
        m.pos     = 0;
        m.fs      = 1'b0;
        m.rs      = 1'b0;
        m.rcnt    = 0;
        m.tmo     = 1'b0;
        m.waited  = 0;
        m.hist    = 4'b0;
        return m;
    endfunction

    function automatic model_t model_step(model_t m, bit s, int flen, int tmo);
        bit e;
        m.hist = {m.hist[2:0], s};
        // A SYNC sampled at edge N acts at edge N+2; only a low-to-high change counts.
        e    = m.hist[2] && !m.hist[3];
        m.fs = 1'b0;
        m.rs = 1'b0;
        if (!m.aligned) begin
            if (m.waited < tmo) m.waited++;
            if (m.waited >= tmo) m.tmo = 1'b1;
            if (e) begin
                m.aligned = 1'b1;
                m.pos     = 0;
                m.fs      = 1'b1;
            end
        end else if (e && m.pos != flen - 1) begin
            m.pos = 0;
            m.fs  = 1'b1;
            m.rs  = 1'b1;
            if (m.rcnt < 255) m.rcnt++;
        end else begin
            m.pos = (m.pos + 1) % flen;
            m.fs  = (m.pos == 0);
        end
        return m;
    endfunction

    function automatic logic [27:0] exp_vec(model_t m);
        return {m.fs, 16'(m.pos), m.aligned, m.rs, 8'(m.rcnt), m.tmo};
    endfunction

    function automatic logic [27:0] act_a();
        return {bus_a.frame_start, 16'(bus_a.frame_pos), bus_a.aligned, bus_a.resync,
                bus_a.resync_count, bus_a.sync_timeout};
    endfunction

    function automatic logic [27:0] act_b();
        return {bus_b.frame_start, 16'(bus_b.frame_pos), bus_b.aligned, bus_b.resync,
                bus_b.resync_count, bus_b.sync_timeout};
    endfunction

    // Called just after a falling edge; returns just after the next falling edge.
    task automatic cycle(input bit sa, input bit sb, input bit short_pulse);
        if (short_pulse) #4;
        bus_a.sync_in = sa;
        bus_b.sync_in = sb;
        @(posedge clk);
        ma = model_step(ma, sa, int'(LEN_A), int'(TMO_A));
        mb = model_step(mb, sb, int'(LEN_B), int'(TMO_B));
        cyc++;
        if (short_pulse) begin
            #2;
            bus_a.sync_in = 1'b0;
            bus_b.sync_in = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic assert_reset(input bit sa);
        #1;
        reset_n       = 1'b0;
        bus_a.sync_in = sa;
        bus_b.sync_in = 1'b0;
        ma            = model_reset();
        mb            = model_reset();
        #1;
    endtask

    task automatic release_reset();
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        assert_reset(1'b0);
        checks++;
        if (act_a() !== 28'h0) begin
            failures++;
            $display("FAIL reset_a got %h want %h", act_a(), 28'h0);
        end
        checks++;
        if (act_b() !== 28'h0) begin
            failures++;
            $display("FAIL reset_b got %h want %h", act_b(), 28'h0);
        end
        release_reset();
        for (int i = 0; i < 100; i++) begin
            cycle(1'b0, 1'b0, 1'b0);
            checks++;
            if (act_a() !== exp_vec(ma)) begin
                failures++;
                $display("FAIL idle cyc=%0d got %h want %h", i, act_a(), exp_vec(ma));
            end
        end
    endtask

    task automatic test_align();
        int hold;
        int n_fs;
        int n_rs;
        int first_al;
        int exp_fs;
        hold     = int'($urandom_range(3, 8));
        n_fs     = 0;
        n_rs     = 0;
        first_al = -1;
        for (int i = 0; i < hold + 60; i++) begin
            cycle(i < hold, 1'b0, 1'b0);
            checks++;
            if (act_a() !== exp_vec(ma)) begin
                failures++;
                $display("FAIL align cyc=%0d got %h want %h", i, act_a(), exp_vec(ma));
            end
            if (bus_a.frame_start === 1'b1) n_fs++;
            if (bus_a.resync === 1'b1) n_rs++;
            if (bus_a.aligned === 1'b1 && first_al < 0) first_al = i;
        end
        exp_fs = (hold + 57) / 16 + 1;
        checks++;
        if (first_al !== 2) begin
            failures++;
            $display("FAIL align_latency got %0d want %0d", first_al, 2);
        end
        checks++;
        if (n_fs !== exp_fs) begin
            failures++;
            $display("FAIL align_fs_count got %0d want %0d", n_fs, exp_fs);
        end
        checks++;
        if (n_rs !== 0) begin
            failures++;
            $display("FAIL align_resync got %0d want %0d", n_rs, 0);
        end
    endtask

    task automatic test_in_phase();
        int last_fs;
        int n_fs;
        int guard;
        last_fs = -1;
        n_fs    = 0;
        for (int f = 0; f < 6; f++) begin
            guard = 0;
            while (ma.pos != 13 && guard < 40) begin
                cycle(1'b0, 1'b0, 1'b0);
                guard++;
                checks++;
                if (act_a() !== exp_vec(ma)) begin
                    failures++;
                    $display("FAIL in_phase got %h want %h", act_a(), exp_vec(ma));
                end
                if (bus_a.frame_start === 1'b1) begin
                    if (last_fs >= 0) begin
                        checks++;
                        if (cyc - last_fs !== 16) begin
                            failures++;
                            $display("FAIL in_phase_period got %0d want %0d",
                                     cyc - last_fs, 16);
                        end
                    end
                    last_fs = cyc;
                    n_fs++;
                end
            end
            if (guard >= 40) begin
                failures++;
                $display("FAIL in_phase_wait got pos %0d want %0d", ma.pos, 13);
            end
            cycle(1'b1, 1'b0, 1'b0);
            checks++;
            if (act_a() !== exp_vec(ma)) begin
                failures++;
                $display("FAIL in_phase_drive got %h want %h", act_a(), exp_vec(ma));
            end
        end
        checks++;
        if (n_fs < 5) begin
            failures++;
            $display("FAIL in_phase_fs_count got %0d want >=%0d", n_fs, 5);
        end
        checks++;
        if (bus_a.resync_count !== 8'd0) begin
            failures++;
            $display("FAIL in_phase_rcnt got %0d want %0d", bus_a.resync_count, 0);
        end
    endtask

    task automatic test_resync();
        int t;
        int drive_pos;
        int guard;
        int want;
        for (int i = 0; i < 300; i++) begin
            t         = (i == 0) ? 5 : int'($urandom_range(0, 14));
            drive_pos = (t + 14) % 16;
            cycle(1'b0, 1'b0, 1'b0);
            guard = 0;
            while (ma.pos != drive_pos && guard < 40) begin
                cycle(1'b0, 1'b0, 1'b0);
                guard++;
                checks++;
                if (act_a() !== exp_vec(ma)) begin
                    failures++;
                    $display("FAIL resync_wait got %h want %h", act_a(), exp_vec(ma));
                end
            end
            if (guard >= 40) begin
                failures++;
                $display("FAIL resync_wait_bound got pos %0d want %0d", ma.pos, drive_pos);
            end
            cycle(1'b1, 1'b0, 1'b0);
            cycle(1'b0, 1'b0, 1'b0);
            checks++;
            if (bus_a.frame_pos !== W_A'(t)) begin
                failures++;
                $display("FAIL resync_phase got %0d want %0d", bus_a.frame_pos, t);
            end
            cycle(1'b0, 1'b0, 1'b0);
            want = (i + 1 > 255) ? 255 : i + 1;
            checks++;
            if ({bus_a.resync, bus_a.frame_start, bus_a.frame_pos, bus_a.resync_count}
                !== {1'b1, 1'b1, W_A'(0), 8'(want)}) begin
                failures++;
                $display("FAIL resync_event rs=%b fs=%b pos=%0d rcnt=%0d want 1 1 0 %0d",
                         bus_a.resync, bus_a.frame_start, bus_a.frame_pos,
                         bus_a.resync_count, want);
            end
            checks++;
            if (act_a() !== exp_vec(ma)) begin
                failures++;
                $display("FAIL resync_model got %h want %h", act_a(), exp_vec(ma));
            end
        end
        cycle(1'b0, 1'b0, 1'b0);
        checks++;
        if (bus_a.resync_count !== 8'd255 || bus_a.resync !== 1'b0) begin
            failures++;
            $display("FAIL resync_saturate got %0d rs=%b want 255 rs=0",
                     bus_a.resync_count, bus_a.resync);
        end
    endtask

    task automatic test_short_pulse();
        int n_al;
        int n_fs;
        int n_rs;
        int guard;
        bit prev_al;
        @(negedge clk);
        assert_reset(1'b0);
        release_reset();
        repeat (3) cycle(1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b1);
        n_al    = 0;
        n_fs    = 0;
        prev_al = 1'b0;
        for (int j = 1; j <= 40; j++) begin
            cycle(1'b0, 1'b0, 1'b0);
            checks++;
            if (act_a() !== exp_vec(ma)) begin
                failures++;
                $display("FAIL short_wait j=%0d got %h want %h", j, act_a(), exp_vec(ma));
            end
            if (bus_a.aligned === 1'b1 && !prev_al) n_al++;
            prev_al = bus_a.aligned;
            if (bus_a.frame_start === 1'b1) n_fs++;
        end
        checks++;
        if (n_al !== 1 || n_fs !== 3) begin
            failures++;
            $display("FAIL short_align got al=%0d fs=%0d want al=1 fs=3", n_al, n_fs);
        end
        guard = 0;
        while (ma.pos != 3 && guard < 40) begin
            cycle(1'b0, 1'b0, 1'b0);
            guard++;
        end
        if (guard >= 40) begin
            failures++;
            $display("FAIL short_wait_bound got pos %0d want %0d", ma.pos, 3);
        end
        cycle(1'b1, 1'b0, 1'b1);
        n_rs = 0;
        for (int j = 0; j < 10; j++) begin
            cycle(1'b0, 1'b0, 1'b0);
            checks++;
            if (act_a() !== exp_vec(ma)) begin
                failures++;
                $display("FAIL short_run j=%0d got %h want %h", j, act_a(), exp_vec(ma));
            end
            if (bus_a.resync === 1'b1) n_rs++;
        end
        checks++;
        if (n_rs !== 1 || bus_a.resync_count !== 8'd1) begin
            failures++;
            $display("FAIL short_resync got rs=%0d rcnt=%0d want rs=1 rcnt=1",
                     n_rs, bus_a.resync_count);
        end
    endtask

    task automatic test_reset_mid();
        int guard;
        @(negedge clk);
        assert_reset(1'b0);
        release_reset();
        cycle(1'b1, 1'b0, 1'b0);
        guard = 0;
        while (!(ma.aligned && ma.pos == 9) && guard < 60) begin
            cycle(1'b0, 1'b0, 1'b0);
            guard++;
        end
        checks++;
        if (bus_a.frame_pos !== W_A'(9) || guard >= 60) begin
            failures++;
            $display("FAIL reset_mid_setup got pos %0d want %0d", bus_a.frame_pos, 9);
        end
        assert_reset(1'b1);
        checks++;
        if (act_a() !== 28'h0) begin
            failures++;
            $display("FAIL reset_mid_async got %h want %h", act_a(), 28'h0);
        end
        release_reset();
        for (int i = 0; i < 7; i++) begin
            cycle(1'b1, 1'b0, 1'b0);
            checks++;
            if (act_a() !== exp_vec(ma)) begin
                failures++;
                $display("FAIL reset_mid_model i=%0d got %h want %h", i, act_a(), exp_vec(ma));
            end
            checks++;
            if ({bus_a.aligned, bus_a.frame_start} !== {i >= 2, i == 2}) begin
                failures++;
                $display("FAIL reset_mid_align i=%0d got al=%b fs=%b want al=%b fs=%b", i,
                         bus_a.aligned, bus_a.frame_start, i >= 2, i == 2);
            end
        end
        cycle(1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_timeout();
        int e;
        @(negedge clk);
        assert_reset(1'b0);
        release_reset();
        for (int i = 0; i < 70; i++) begin
            cycle(1'b0, 1'b0, 1'b0);
            checks++;
            if (act_b() !== exp_vec(mb)) begin
                failures++;
                $display("FAIL timeout_model i=%0d got %h want %h", i, act_b(), exp_vec(mb));
            end
            checks++;
            if (bus_b.sync_timeout !== (i + 1 >= 50)) begin
                failures++;
                $display("FAIL timeout_edge i=%0d got %b want %b", i,
                         bus_b.sync_timeout, i + 1 >= 50);
            end
        end
        for (int i = 0; i < 12; i++) begin
            cycle(1'b0, i < 2, 1'b0);
            checks++;
            if (act_b() !== exp_vec(mb)) begin
                failures++;
                $display("FAIL timeout_late i=%0d got %h want %h", i, act_b(), exp_vec(mb));
            end
        end
        checks++;
        if ({bus_b.aligned, bus_b.sync_timeout} !== 2'b11) begin
            failures++;
            $display("FAIL timeout_sticky got al=%b tmo=%b want al=1 tmo=1",
                     bus_b.aligned, bus_b.sync_timeout);
        end
        // SYNC landing one edge before, on, or after the timeout edge.
        for (int r = 0; r < 3; r++) begin
            e = 49 + int'($urandom_range(0, 2));
            @(negedge clk);
            assert_reset(1'b0);
            release_reset();
            for (int i = 0; i < 60; i++) begin
                cycle(1'b0, i + 1 == e - 2, 1'b0);
                checks++;
                if (act_b() !== exp_vec(mb)) begin
                    failures++;
                    $display("FAIL coincide_model e=%0d i=%0d got %h want %h", e, i,
                             act_b(), exp_vec(mb));
                end
                checks++;
                if ({bus_b.aligned, bus_b.sync_timeout} !==
                    {i + 1 >= e, (e >= 50) && (i + 1 >= 50)}) begin
                    failures++;
                    $display("FAIL coincide e=%0d i=%0d got al=%b tmo=%b want al=%b tmo=%b",
                             e, i, bus_b.aligned, bus_b.sync_timeout, i + 1 >= e,
                             (e >= 50) && (i + 1 >= 50));
                end
            end
        end
    endtask

    initial begin
        checks        = 0;
        failures      = 0;
        cyc           = 0;
        reset_n       = 1'b0;
        bus_a.sync_in = 1'b0;
        bus_b.sync_in = 1'b0;
        ma            = model_reset();
        mb            = model_reset();
        test_reset();
        test_align();
        test_in_phase();
        test_resync();
        test_short_pulse();
        test_reset_mid();
        test_timeout();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got time %0t want completion", $time);
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/sync_catch.md
# sync_catch

Receive side of the board-level SYNC line. Takes the one-shot (or periodic) SYNC pulse from the upstream sync generator, synchronizes it into the local `clk` domain and aligns a free-running frame position counter to it. Reports alignment, out-of-phase re-syncs and a missing-SYNC timeout to the capture and control logic downstream.

## Interface
- `FRAME_LEN`, 1024: frame length in clk cycles, must be ≥ 2.
- `TIMEOUT`, 1100000: cycles after reset without SYNC before `sync_timeout` is raised. Must be < 2^24. The default exceeds the upstream generator's 2^20-cycle power-up delay.
- `CNT_W`, $clog2(FRAME_LEN): width of `frame_pos`.

Ports:
- `clk` in 1: system clock.
- `reset_n` in 1: reset, asynchronous, active-low.
- `sync_in` in 1: SYNC line, asynchronous to `clk`, active-high.
- `frame_start` out 1: one-cycle pulse when `frame_pos` becomes 0.
- `frame_pos` out CNT_W: position within the current frame.
- `aligned` out 1: at least one SYNC has been accepted since reset.
- `resync` out 1: one-cycle pulse on an out-of-phase SYNC.
- `resync_count` out 8: saturating count of `resync` pulses.
- `sync_timeout` out 1: sticky flag, no SYNC seen within TIMEOUT cycles.

## Operation
- **Input conditioning**
  - `sync_in` passes through a 2-flop synchronizer (s1, s2), then an edge register s3.
  - Edge `s_edge = s2 & ~s3`.
  - A level held high for many cycles produces exactly one `s_edge`.
  - If `sync_in` is already high at reset release, that counts as an edge.
- **Reset values:** all flops 0; state WAIT; every output 0.
- **WAIT state**
  - `frame_pos` held at 0; `aligned` = 0.
  - A 24-bit timeout counter increments each cycle and saturates at TIMEOUT.
  - When the counter reaches TIMEOUT, `sync_timeout` is set to 1. It stays set until reset; a later SYNC does not clear it.
  - On `s_edge`: go to RUN, `frame_pos` <= 0, `frame_start` <= 1, `aligned` <= 1.
  - The first SYNC never asserts `resync`.
- **RUN state**
  - `frame_pos` <= (`frame_pos` == FRAME_LEN-1) ? 0 : `frame_pos`+1.
  - `frame_start` = 1 in the cycle `frame_pos` becomes 0.
  - The timeout counter is frozen.
- **`s_edge` in RUN**
  - If `frame_pos` == FRAME_LEN-1: the SYNC is in phase. Normal wrap, no `resync`.
  - Otherwise: `frame_pos` <= 0, `frame_start` <= 1, `resync` <= 1 for one cycle, and `resync_count` <= min(`resync_count`+1, 255).
- **Exits from RUN:** RUN is left only by reset; `aligned` never deasserts except on reset.
- **Reset mid-frame:** all state and outputs return to reset values immediately (asynchronous). The timeout counter restarts from 0 after release.

## Timing
- **SYNC to alignment:** `sync_in` sampled high at clk edge N gives `s_edge` between N+1 and N+2.
  - `frame_start`, `aligned`, `frame_pos`=0 (and `resync` if applicable) are visible after edge N+2.
  - `frame_pos` = 1 after N+3.
- **Outputs:** all are registered; no combinational path from `sync_in`.
- **`frame_start` period:** asserts every FRAME_LEN cycles, as the clk cycle in which `frame_pos` = 0.
- **Timeout:** `sync_timeout` rises at the TIMEOUT-th clk edge after reset release, provided no `s_edge` occurred in WAIT before then.
- **SYNC on the timeout edge:** if `s_edge` and the timeout compare coincide on the same edge, both take effect (`aligned`=1, `sync_timeout`=1).

## Test plan
- Reset, FRAME_LEN=16, no SYNC → all outputs 0 and `frame_pos`=0 for 100 cycles. Then `sync_in` high at edge 100 (held 5 cycles) → `aligned`=1 and `frame_start` pulse after edge 102; `frame_pos` counts 0..15; `frame_start` every 16 cycles; exactly one alignment, `resync`=0.
- After alignment, assert `sync_in` every 16 cycles in phase (SYNC sampled 2 edges before the natural wrap) → `resync` never asserts, `resync_count`=0, `frame_start` period stays 16.
- While aligned, assert `sync_in` with `frame_pos` at 5 when the edge registers → `frame_pos`=0 and `frame_start` after that edge; `resync` for 1 cycle; `resync_count`=1. Repeat 300 times → `resync_count` saturates at 255.
- TIMEOUT=50, no SYNC → `sync_timeout` rises at edge 50 after reset release and stays high. A later SYNC → `aligned`=1, `sync_timeout` still 1.
- Reset asserted mid-frame at `frame_pos`=9 → all outputs 0 asynchronously. After release, `sync_in` already high → alignment 2 edges after release.
- `sync_in` pulse shorter than one clk period, sampled once → exactly one `frame_start`/alignment event.
